operand_bank: RTL and testbench
===============================

# operand_bank

Clocked register bank that sources the two operand bytes and the select bit for the byte input selector directly downstream. It holds NUM_REGS 8-bit registers, accepts one write per cycle, and performs two registered reads per cycle. It presents x, y and a delayed copy of the select bit, all aligned, so that the selector output is valid one cycle after the read request.

## Interface
- NUM_REGS, 8: number of 8-bit registers; power of two, 2..16.
- ADDR_W, $clog2(NUM_REGS): address width; derived, not overridden.

- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_en  input  1  read request this cycle.
- ra_x  input  ADDR_W  read address for operand x.
- ra_y  input  ADDR_W  read address for operand y.
- sel_in  input  1  select bit travelling with this read.
- wr_en  input  1  write request this cycle.
- wa  input  ADDR_W  write address.
- wd  input  8  write data.
- x  output  8  operand x; feeds selector x.
- y  output  8  operand y; feeds selector y.
- sel  output  1  delayed sel_in; feeds selector sel.
- valid  output  1  x/y/sel hold a completed read.

## Operation
- Storage: NUM_REGS × 8-bit registers. All registers clear to 0x00 on rst.
- Write: when wr_en=1, mem[wa] <= wd at the clock edge. There is no write-disable register; every address is writable.
- Read pipeline, one stage:
  - rd_en=1 at edge N: x <= mem[ra_x], y <= mem[ra_y], sel <= sel_in, valid <= 1.
  - rd_en=0 at edge N: x, y and sel hold their previous values; valid <= 0.
- Read-during-write to the same address in the same cycle:
  - With bypass (see Configuration): the read returns wd, the new value.
  - Without bypass: the read returns the old mem contents.
  - This applies independently to ra_x and ra_y. If both match wa, both ports get the same result.
- ra_x = ra_y is legal. Both ports return the same byte.
- Addresses are ADDR_W bits wide, so no address can be out of range.
- Reset outputs: x=0x00, y=0x00, sel=0, valid=0. All registers are 0x00.
- rst dominates rd_en and wr_en. A write presented in the reset cycle is discarded. A read presented in the reset cycle yields valid=0 on the next cycle.
- Reset mid-operation: any read in flight is dropped. valid deasserts on the edge where rst is sampled high.

## Timing
- Write latency: 1 cycle. A read issued the cycle after a write sees the new data, with or without bypass.
- Read latency: 1 cycle. The request at edge N produces x/y/sel/valid after edge N.
- Throughput: one read and one write every cycle, with no stalls.
- Downstream selector output (z) is combinationally valid whenever valid=1.
- There are no combinational paths from inputs to outputs. All outputs come directly from flops.

## Configuration
- OPERAND_BANK_BYPASS_EN defined: same-cycle write-to-read forwarding is enabled per port, as described in Operation.
- OPERAND_BANK_BYPASS_EN undefined: there is no forwarding. A same-address read in the write cycle returns the pre-write value. The bypass comparators and muxes are not built.
- All other behaviour is identical in both builds.

## Test plan
- Reset: hold rst for 2 cycles with wr_en=1, wa=3, wd=0xAA. Then issue a read with ra_x=3, ra_y=3. Required: x=0x00, y=0x00, valid=0 during reset, then valid=1 with x=y=0x00.
- Basic write/read: write mem[1]=0x5C, then mem[6]=0xE1. Next cycle, read ra_x=1, ra_y=6, sel_in=1. Required, one cycle later: x=0x5C, y=0xE1, sel=1, valid=1.
- Same-cycle hazard: mem[2]=0x11. In one cycle, issue wr_en with wa=2, wd=0x99 and rd_en with ra_x=2, ra_y=2. Required: x=y=0x99 with OPERAND_BANK_BYPASS_EN, x=y=0x11 without it. A read the following cycle returns 0x99 in both builds.
- Hold behaviour: after a valid read of x=0x5C, deassert rd_en for 3 cycles while writing mem[1]=0x00. Required: x stays 0x5C, valid=0, sel unchanged.
- Back-to-back streaming: issue reads every cycle over addresses 0..7 with sel_in alternating 0/1, after preloading mem[i]=i*0x11. Required: x=i*0x11 and sel matches the alternating pattern, each one cycle later, with valid continuously 1.
- Reset mid-stream: assert rst for one cycle during the streaming test. Required: valid=0 and x=y=0x00 on the next cycle, and all registers read back 0x00 afterwards.

Source files
------------

// File: rtl/operand_bank.sv
// Register bank feeding the byte selector: one write and two registered reads per cycle.
// Define OPERAND_BANK_BYPASS_EN to forward same-cycle write data to matching read ports.
module operand_bank #(
   parameter int unsigned NUM_REGS = 8,
   localparam int unsigned ADDR_W = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] ra_x,
   input  logic [ADDR_W-1:0] ra_y,
   input  logic              sel_in,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wa,
   input  logic [7:0]        wd,
   output logic [7:0]        x,
   output logic [7:0]        y,
   output logic              sel,
   output logic              valid
);

   logic [7:0] mem_q [NUM_REGS];

   logic [7:0] x_q, x_d;
   logic [7:0] y_q, y_d;
   logic       sel_q, sel_d;
   logic       valid_q, valid_d;

   logic [7:0] rdata_x, rdata_y;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (wr_en) begin
         mem_q[wa] <= wd;
      end
   end

`ifdef OPERAND_BANK_BYPASS_EN
   // Each port independently picks up the byte being written this cycle.
   always_comb begin
      rdata_x = mem_q[ra_x];
      rdata_y = mem_q[ra_y];
      if (wr_en && (wa == ra_x)) begin
         rdata_x = wd;
      end
      if (wr_en && (wa == ra_y)) begin
         rdata_y = wd;
      end
   end
`else
   always_comb begin
      rdata_x = mem_q[ra_x];
      rdata_y = mem_q[ra_y];
   end
`endif

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      sel_d   = sel_q;
      valid_d = 1'b0;
      if (rd_en) begin
         x_d     = rdata_x;
         y_d     = rdata_y;
         sel_d   = sel_in;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q     <= 8'h00;
         y_q     <= 8'h00;
         sel_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
      end
   end

   assign x     = x_q;
   assign y     = y_q;
   assign sel   = sel_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_operand_bank.sv
// Directed self-checking bench for operand_bank; expectations follow the build's bypass setting.
module tb_operand_bank;

   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned ADDR_W   = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              rd_en;
   logic [ADDR_W-1:0] ra_x;
   logic [ADDR_W-1:0] ra_y;
   logic              sel_in;
   logic              wr_en;
   logic [ADDR_W-1:0] wa;
   logic [7:0]        wd;
   logic [7:0]        x;
   logic [7:0]        y;
   logic              sel;
   logic              valid;

   int tests_run    = 0;
   int tests_failed = 0;

   operand_bank #(
      .NUM_REGS(NUM_REGS)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .rd_en  (rd_en),
      .ra_x   (ra_x),
      .ra_y   (ra_y),
      .sel_in (sel_in),
      .wr_en  (wr_en),
      .wa     (wa),
      .wd     (wd),
      .x      (x),
      .y      (y),
      .sel    (sel),
      .valid  (valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [7:0] ex, input logic [7:0] ey,
                            input logic es, input logic ev);
      check({tag, ".x"}, x, ex);
      check({tag, ".y"}, y, ey);
      check({tag, ".sel"}, {7'd0, sel}, {7'd0, es});
      check({tag, ".valid"}, {7'd0, valid}, {7'd0, ev});
   endtask

   logic [7:0] hazard_exp;
   logic [7:0] ev_x, ev_y;
   logic [2:0] ai;

   initial begin
`ifdef OPERAND_BANK_BYPASS_EN
      hazard_exp = 8'h99;
`else
      hazard_exp = 8'h11;
`endif
      rst = 1'b1; rd_en = 1'b1; ra_x = 3'd3; ra_y = 3'd3; sel_in = 1'b1;
      wr_en = 1'b1; wa = 3'd3; wd = 8'hAA;

      // Reset held two cycles with a write and read pending.
      step();
      check_out("rst0", 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      check_out("rst1", 8'h00, 8'h00, 1'b0, 1'b0);
      rst = 1'b0; wr_en = 1'b0; sel_in = 1'b0;
      step();
      check_out("rst_read", 8'h00, 8'h00, 1'b0, 1'b1);

      // Basic write then read.
      rd_en = 1'b0; wr_en = 1'b1; wa = 3'd1; wd = 8'h5C;
      step();
      check("idle.valid", {7'd0, valid}, 8'h00);
      wa = 3'd6; wd = 8'hE1;
      step();
      wr_en = 1'b0; rd_en = 1'b1; ra_x = 3'd1; ra_y = 3'd6; sel_in = 1'b1;
      step();
      check_out("basic", 8'h5C, 8'hE1, 1'b1, 1'b1);

      // Hold: no reads while mem[1] is cleared.
      rd_en = 1'b0; wr_en = 1'b1; wa = 3'd1; wd = 8'h00; sel_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out("hold", 8'h5C, 8'hE1, 1'b1, 1'b0);
      end
      wr_en = 1'b0; rd_en = 1'b1; ra_x = 3'd1; ra_y = 3'd1;
      step();
      check_out("hold_after", 8'h00, 8'h00, 1'b0, 1'b1);

      // Same-cycle read/write hazard on address 2.
      rd_en = 1'b0; wr_en = 1'b1; wa = 3'd2; wd = 8'h11;
      step();
      wd = 8'h99; rd_en = 1'b1; ra_x = 3'd2; ra_y = 3'd2; sel_in = 1'b1;
      step();
      check_out("hazard", hazard_exp, hazard_exp, 1'b1, 1'b1);
      wr_en = 1'b0; sel_in = 1'b0;
      step();
      check_out("hazard_next", 8'h99, 8'h99, 1'b0, 1'b1);

      // Preload mem[i] = i*0x11, then stream reads every cycle.
      rd_en = 1'b0; wr_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wa = 3'(i); wd = 8'(i * 8'h11);
         step();
      end
      wr_en = 1'b0; rd_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ai = 3'(i);
         ra_x = ai; ra_y = 3'd7 - ai; sel_in = ai[0];
         ev_x = 8'(i * 8'h11); ev_y = 8'((7 - i) * 8'h11);
         step();
         check_out("stream", ev_x, ev_y, ai[0], 1'b1);
      end

      // Reset mid-stream drops the read in flight and clears storage.
      for (int i = 0; i < 3; i++) begin
         ai = 3'(i + 4);
         ra_x = ai; ra_y = ai; sel_in = ai[0];
         step();
         check_out("stream2", 8'(ai * 8'h11), 8'(ai * 8'h11), ai[0], 1'b1);
      end
      rst = 1'b1; ra_x = 3'd7; ra_y = 3'd7; sel_in = 1'b1;
      step();
      check_out("mid_rst", 8'h00, 8'h00, 1'b0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ai = 3'(i);
         ra_x = ai; ra_y = 3'd7 - ai; sel_in = ai[0];
         step();
         check_out("post_rst", 8'h00, 8'h00, ai[0], 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, expected finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
